// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle 32-bit datapath.
// It steps each instruction through fetch, decode, execute, memory and writeback, and faults on a memory wait timeout.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       MemtoReg,
  output logic       RegDst,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       instr_done,
  output logic       illegal_op,
  output logic       mem_fault,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXECUTE   = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_FAULT     = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(MEM_TIMEOUT);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] wait_q, wait_d;
  logic             mem_state;

  always_comb begin
    state_d   = state_q;
    wait_d    = '0;
    mem_state = (state_q == S_FETCH) || (state_q == S_MEM_READ) ||
                (state_q == S_MEM_WRITE);
    case (state_q)
      S_FETCH:     if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_R:         state_d = S_EXECUTE;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          OP_ADDI:      state_d = S_ADDI_EX;
          default:      state_d = S_FETCH;
        endcase
      end
      S_MEM_ADDR:  state_d = (opcode == OP_LW) ? S_MEM_READ : S_MEM_WRITE;
      S_MEM_READ:  if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) state_d = S_FETCH;
      S_EXECUTE:   state_d = S_R_WB;
      S_ADDI_EX:   state_d = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB: state_d = S_FETCH;
      S_FAULT:     state_d = S_FAULT;
      default:     state_d = S_FAULT;
    endcase
    // The counter holds the number of wait cycles already spent in this memory state.
    // A ready in the cycle it equals TIMEOUT still completes normally.
    if (mem_state && !mem_ready) begin
      if (wait_q >= TIMEOUT) state_d = S_FAULT;
      else                   wait_d  = wait_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSource    = 2'b00;
    instr_done  = 1'b0;
    illegal_op  = 1'b0;
    mem_fault   = 1'b0;
    state       = reset ? 4'd0 : state_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'b11;
          if (!(opcode inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI})) begin
            illegal_op = 1'b1;
            instr_done = 1'b1;
          end
        end
        S_MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        S_MEM_READ: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        S_MEM_WB: begin
          RegWrite   = 1'b1;
          MemtoReg   = 1'b1;
          instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = mem_ready;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_R_WB: begin
          RegWrite   = 1'b1;
          RegDst     = 1'b1;
          instr_done = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
          instr_done  = 1'b1;
        end
        S_JUMP: begin
          PCWrite    = 1'b1;
          PCSource   = 2'b10;
          instr_done = 1'b1;
        end
        S_ADDI_EX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = 2'b11;
        end
        S_ADDI_WB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        S_FAULT: mem_fault = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: every cycle's state and control word are checked against hand-written constants.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic       instr_done, illegal_op, mem_fault;
  logic [3:0] state;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  multicycle_control #(.MEM_TIMEOUT(15), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemtoReg(MemtoReg), .RegDst(RegDst), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .instr_done(instr_done), .illegal_op(illegal_op), .mem_fault(mem_fault),
    .state(state)
  );

  always #5 clk = ~clk;

  // Bit order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
  // RegWrite ALUSrcA ALUSrcB[2] ALUOp[2] PCSource[2] instr_done illegal_op mem_fault
  logic [18:0] ctl;
  assign ctl = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
                RegDst, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource,
                instr_done, illegal_op, mem_fault};

  localparam logic [18:0] C_ZERO   = 19'b0;
  localparam logic [18:0] C_F_WAIT = {1'b0,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_F_RDY  = {1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_DEC    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_DEC_IL = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,2'b00,2'b00,1'b1,1'b1,1'b0};
  localparam logic [18:0] C_MADDR  = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_MREAD  = {1'b0,1'b0,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_MWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_MW_WT  = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_MW_RDY = {1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_EXE    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b10,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_RWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_BR     = {1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b00,2'b01,2'b01,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_JMP    = {1'b1,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b10,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_AEX    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,2'b10,2'b11,2'b00,1'b0,1'b0,1'b0};
  localparam logic [18:0] C_AWB    = {1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b1,1'b0,2'b00,2'b00,2'b00,1'b1,1'b0,1'b0};
  localparam logic [18:0] C_FAULT  = 19'b1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after a posedge; sampling happens 3 units later, mid-cycle.
  task automatic cyc(input string tag, input logic [3:0] st, input logic [18:0] v);
    #3;
    check({tag, "/state"}, 32'(state), 32'(st));
    check({tag, "/ctl"}, 32'(ctl), 32'(v));
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ready = 1'b1;
    opcode    = 6'b000000;

    for (int i = 0; i < 3; i++) cyc("reset", 4'd0, C_ZERO);
    reset = 1'b0;

    // R-type: fetch in the first cycle after release
    cyc("r_fetch", 4'd0, C_F_RDY);
    cyc("r_dec", 4'd1, C_DEC);
    cyc("r_exe", 4'd6, C_EXE);
    cyc("r_wb", 4'd7, C_RWB);

    opcode = 6'b100011;
    cyc("lw_fetch", 4'd0, C_F_RDY);
    cyc("lw_dec", 4'd1, C_DEC);
    cyc("lw_addr", 4'd2, C_MADDR);
    cyc("lw_read", 4'd3, C_MREAD);
    cyc("lw_wb", 4'd4, C_MWB);

    opcode = 6'b101011;
    cyc("sw_fetch", 4'd0, C_F_RDY);
    cyc("sw_dec", 4'd1, C_DEC);
    cyc("sw_addr", 4'd2, C_MADDR);
    cyc("sw_write", 4'd5, C_MW_RDY);

    opcode = 6'b000100;
    cyc("beq_fetch", 4'd0, C_F_RDY);
    cyc("beq_dec", 4'd1, C_DEC);
    cyc("beq_br", 4'd8, C_BR);

    opcode = 6'b000010;
    cyc("j_fetch", 4'd0, C_F_RDY);
    cyc("j_dec", 4'd1, C_DEC);
    cyc("j_jmp", 4'd9, C_JMP);

    opcode = 6'b001000;
    cyc("addi_fetch", 4'd0, C_F_RDY);
    cyc("addi_dec", 4'd1, C_DEC);
    cyc("addi_ex", 4'd10, C_AEX);
    cyc("addi_wb", 4'd11, C_AWB);

    // Fetch stall of 5 cycles, then a jump to finish the instruction
    opcode    = 6'b000010;
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) cyc("stall_fetch", 4'd0, C_F_WAIT);
    mem_ready = 1'b1;
    cyc("stall_fetch_rdy", 4'd0, C_F_RDY);
    cyc("stall_dec", 4'd1, C_DEC);
    cyc("stall_jmp", 4'd9, C_JMP);

    // Illegal opcode
    opcode = 6'b111111;
    cyc("ill_fetch", 4'd0, C_F_RDY);
    cyc("ill_dec", 4'd1, C_DEC_IL);
    opcode = 6'b000010;
    cyc("ill_next_fetch", 4'd0, C_F_RDY);
    cyc("ill_next_dec", 4'd1, C_DEC);
    cyc("ill_next_jmp", 4'd9, C_JMP);

    // lw with 15 wait cycles, ready arriving when the counter is at the limit
    opcode = 6'b100011;
    cyc("tb_fetch", 4'd0, C_F_RDY);
    cyc("tb_dec", 4'd1, C_DEC);
    cyc("tb_addr", 4'd2, C_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) cyc("tb_wait", 4'd3, C_MREAD);
    mem_ready = 1'b1;
    cyc("tb_read_rdy", 4'd3, C_MREAD);
    cyc("tb_wb", 4'd4, C_MWB);

    // lw with mem_ready withheld: one wait cycle too many parks the FSM in FAULT
    cyc("to_fetch", 4'd0, C_F_RDY);
    cyc("to_dec", 4'd1, C_DEC);
    cyc("to_addr", 4'd2, C_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 16; i++) cyc("to_wait", 4'd3, C_MREAD);
    cyc("to_fault", 4'd15, C_FAULT);
    mem_ready = 1'b1;
    for (int i = 0; i < 3; i++) cyc("to_fault_hold", 4'd15, C_FAULT);
    reset = 1'b1;
    cyc("to_reset", 4'd0, C_ZERO);
    reset = 1'b0;
    opcode = 6'b000010;
    cyc("to_rel_fetch", 4'd0, C_F_RDY);
    cyc("to_rel_dec", 4'd1, C_DEC);
    cyc("to_rel_jmp", 4'd9, C_JMP);

    // Reset while a store is waiting on memory
    opcode = 6'b101011;
    cyc("mr_fetch", 4'd0, C_F_RDY);
    cyc("mr_dec", 4'd1, C_DEC);
    cyc("mr_addr", 4'd2, C_MADDR);
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc("mr_wait", 4'd5, C_MW_WT);
    reset = 1'b1;
    cyc("mr_reset", 4'd0, C_ZERO);
    reset     = 1'b0;
    mem_ready = 1'b1;
    cyc("mr_rel_fetch", 4'd0, C_F_RDY);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore-style main control FSM for the multicycle 32-bit datapath. Sequences the instruction register, register file, ALU source muxes, PC update and memory port.
- Decodes the 6-bit opcode latched in the instruction register and steps each instruction through fetch, decode, execute, memory and writeback.
- Adds a memory-ready handshake with a wait timeout. A timeout parks the machine in a fault state.

Parameters:
- MEM_TIMEOUT, 15: maximum consecutive cycles a memory state may wait for mem_ready before faulting (1..255).
- CNT_W, 8: width of the internal wait counter. Must hold MEM_TIMEOUT.

Ports:
- clk, input, 1: single clock; all state changes on posedge.
- reset, input, 1: synchronous, active-high. Sampled on posedge clk.
- opcode, input, 6: instruction bits [31:26] from the instruction register.
- mem_ready, input, 1: memory has completed the current read/write this cycle.
- PCWrite, output, 1: unconditional PC load.
- PCWriteCond, output, 1: PC load if ALU zero (branch).
- IorD, output, 1: memory address select; 0 = PC, 1 = ALUOut.
- MemRead, output, 1: memory read request.
- MemWrite, output, 1: memory write request.
- IRWrite, output, 1: instruction register load enable.
- MemtoReg, output, 1: register write data select; 0 = ALUOut, 1 = MDR.
- RegDst, output, 1: destination register select; 0 = rt, 1 = rd.
- RegWrite, output, 1: register file write enable.
- ALUSrcA, output, 1: ALU A select; 0 = PC, 1 = rs data.
- ALUSrcB, output, 2: ALU B select; 00 = rt data, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- ALUOp, output, 2: 00 = add, 01 = sub, 10 = funct-decoded, 11 = add (addi).
- PCSource, output, 2: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- instr_done, output, 1: one-cycle pulse in the final cycle of every instruction.
- illegal_op, output, 1: one-cycle pulse in DECODE on an unsupported opcode.
- mem_fault, output, 1: sticky; high while in FAULT.
- state, output, 4: current state encoding, for debug.

Behaviour:
- State encoding:
  - FETCH=0, DECODE=1, MEM_ADDR=2, MEM_READ=3, MEM_WB=4, MEM_WRITE=5, EXECUTE=6, R_WB=7, BRANCH=8, JUMP=9, ADDI_EX=10, ADDI_WB=11, FAULT=15.
- Reset:
  - On any posedge with reset=1: state<=FETCH, wait counter<=0, mem_fault<=0.
  - While reset=1, every output is forced to 0 combinationally, including MemRead. state reads 0.
  - Reset takes priority mid-instruction and from FAULT. Nothing partial is written.
- Opcodes: R-type 000000, lw 100011, sw 101011, beq 000100, j 000010, addi 001000. All others are illegal.
- FETCH:
  - Drives MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00.
  - If mem_ready: IRWrite=1, PCWrite=1, next state DECODE.
  - Else: hold, with IRWrite and PCWrite at 0.
- DECODE:
  - Drives ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target into ALUOut).
  - Next state by opcode: lw/sw -> MEM_ADDR; R -> EXECUTE; beq -> BRANCH; j -> JUMP; addi -> ADDI_EX.
  - Illegal opcode: illegal_op=1, instr_done=1, next state FETCH.
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw -> MEM_READ; sw -> MEM_WRITE.
- MEM_READ:
  - Drives MemRead=1, IorD=1.
  - mem_ready -> MEM_WB; otherwise wait.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0, instr_done=1, next state FETCH.
- MEM_WRITE:
  - Drives MemWrite=1, IorD=1. MemWrite stays asserted while waiting.
  - mem_ready: instr_done=1, next state FETCH.
- EXECUTE: ALUSrcA=1, ALUSrcB=00, ALUOp=10, next state R_WB.
- R_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1, next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01, instr_done=1, next state FETCH.
- JUMP: PCWrite=1, PCSource=10, instr_done=1, next state FETCH.
- ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=11, next state ADDI_WB.
- ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1, next state FETCH.
- Unlisted outputs are 0 in every state.
- Latency with mem_ready tied 1: beq/j = 3 cycles, R/sw/addi = 4, lw = 5, illegal = 2.
- Wait counter:
  - Cleared on entry to FETCH, MEM_READ and MEM_WRITE, and on every mem_ready=1 cycle.
  - Increments each cycle in those states while mem_ready=0.
  - When it reaches MEM_TIMEOUT with mem_ready still 0, next state is FAULT.
  - mem_ready=1 in the same cycle the counter hits MEM_TIMEOUT completes normally; no fault.
- FAULT:
  - mem_fault=1; all other outputs 0.
  - Exits only on reset.
- Unused encodings 12-14 go to FAULT next cycle.

Test Plan:
- Reset behaviour: hold reset 3 cycles with mem_ready=1 -> all outputs 0, state=0. Release -> first cycle MemRead=1, IRWrite=1, PCWrite=1.
- Latency per instruction type: mem_ready=1, opcode sequence 000000, 100011, 101011, 000100, 000010, 001000 -> instr_done spacing 4, 5, 4, 3, 3, 4 cycles. RegWrite asserted in R_WB/MEM_WB/ADDI_WB only. MemWrite asserted only for sw.
- Fetch stall: mem_ready=0 for 5 cycles in FETCH, then 1 -> MemRead held 6 cycles. IRWrite/PCWrite pulse once, in the 6th cycle only. No fault.
- Timeout boundary, MEM_TIMEOUT=15, lw:
  - mem_ready arrives on the 15th wait cycle in MEM_READ -> proceeds to MEM_WB.
  - A further run withholding mem_ready -> state=15, mem_fault=1, everything else 0 until reset.
- Illegal opcode: opcode=111111 -> illegal_op and instr_done pulse together in DECODE. Next state FETCH; no RegWrite or MemWrite.
- Reset mid-instruction: assert reset during MEM_WRITE with mem_ready=0 -> MemWrite drops to 0 the same cycle. After release, state=FETCH and mem_fault=0.
